regfile_sequencer: RTL
======================

Name: regfile_sequencer

Overview:
Command-driven master for the team's general-purpose register file. It accepts READ/WRITE/ADD/SUB commands over a valid/ready interface and drives the register file's two read-address ports and its single write port. It accounts for the register file's one-cycle registered read latency and returns one response per command. It sits between a host or test controller and the register file instance.

Parameters:
WORD_SIZE, 16, data width; must match the register file.
ADDR_SIZE, 3, register address width; must match the register file.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  opcode: 00 READ, 01 WRITE, 10 ADD, 11 SUB
cmd_dst  in  ADDR_SIZE  destination register
cmd_src1  in  ADDR_SIZE  source 1 register
cmd_src2  in  ADDR_SIZE  source 2 register
cmd_data  in  WORD_SIZE  immediate write data (WRITE only)
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_data  out  WORD_SIZE  result value
resp_flag  out  1  carry (ADD) or borrow (SUB); 0 for READ and WRITE
rf_rd_addr1  out  ADDR_SIZE  to register file read port 1
rf_rd_addr2  out  ADDR_SIZE  to register file read port 2
rf_rd_data1  in  WORD_SIZE  from register file; valid the cycle after its address is sampled
rf_rd_data2  in  WORD_SIZE  from register file; valid the cycle after its address is sampled
rf_wrt_addr  out  ADDR_SIZE  write address
rf_wrt_data  out  WORD_SIZE  write data
rf_wrt_enable  out  1  write strobe

Behaviour:
- FSM states: IDLE, RD, EX, WB, RSP.
- Reset (synchronous, any state):
  - next state IDLE; any in-flight command dropped; no write issued.
  - all latched fields, resp_data and resp_flag cleared to 0.
  - resp_valid=0, rf_wrt_enable=0, cmd_ready=1 in the cycle after the reset edge.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op/dst/src1/src2/data.
  - WRITE goes to WB; all other ops go to RD.
- Read addresses: rf_rd_addr1/2 are driven continuously from the latched src1/src2.
- RD: one wait cycle; the register file samples the addresses at the end of this cycle.
- EX: rf_rd_data1/2 are valid. Register the result, then move on (READ to RSP, ADD/SUB to WB).
  - READ: result = rd_data1, flag = 0.
  - ADD: {flag, result} = rd_data1 + rd_data2, computed at WORD_SIZE+1 bits; flag = carry out.
  - SUB: result = rd_data1 - rd_data2 modulo 2^WORD_SIZE; flag = 1 iff rd_data1 < rd_data2 (unsigned borrow).
- WB:
  - rf_wrt_enable=1 for exactly this one cycle; rf_wrt_addr=dst.
  - rf_wrt_data = result (ADD/SUB) or latched data (WRITE).
  - WRITE sets result = data, flag = 0.
  - Next state RSP.
- rf_wrt_enable is 0 in every state other than WB. rf_wrt_addr/data hold their latched values otherwise.
- RSP:
  - resp_valid=1; resp_data/resp_flag stay stable until resp_ready.
  - On resp_ready, go to IDLE; resp_valid drops the next cycle.
- cmd_ready=0 outside IDLE. At most one command is in flight, so there are no data hazards and a READ immediately after a WB returns the new value.
- Latency (command accepted in cycle 0):
  - READ: resp_valid in cycle 3.
  - WRITE: resp_valid in cycle 2.
  - ADD/SUB: write committed at the end of cycle 3; resp_valid in cycle 4.
  - Minimum command-to-command spacing is latency+1 cycles.
- Aliasing: src1==src2 is legal, and dst may equal a source; sources are read before WB.
- Wrap-around: ADD/SUB results wrap modulo 2^WORD_SIZE, with the lost bit reported only via resp_flag.

Decomposition:
- Package regfile_seq_pkg holds:
  - opcode constants OP_READ=2'b00, OP_WRITE=2'b01, OP_ADD=2'b10, OP_SUB=2'b11;
  - FSM state encodings for IDLE/RD/EX/WB/RSP.
- One combinational sub-module, regfile_seq_alu: inputs op, a, b; outputs result and flag (WORD_SIZE+1-bit add/sub).
- Top level: FSM, latches, register-file port drive.

Test Plan:
(bench connects to a live register file instance with WORD_SIZE=16, ADDR_SIZE=3; register file reset only at time 0)
1. After reset, READ r3 -> resp_data=0x0000, resp_flag=0, resp_valid exactly 3 cycles after the accept cycle.
2. WRITE r2=0x1234, then READ r2 -> WRITE response 0x1234 two cycles after accept; READ returns 0x1234; rf_wrt_enable high for exactly 1 cycle.
3. r1=0xFFFF, r2=0x0001, ADD dst=r4 -> resp_data=0x0000, resp_flag=1; then READ r4=0x0000.
4. r1=0x0002, r2=0x0001, SUB dst=r5 src1=r2 src2=r1 -> resp_data=0xFFFF, resp_flag=1; SUB with src1=src2=r1 -> 0x0000, flag 0.
5. Hold resp_ready low 5 cycles during an ADD response -> resp_valid/resp_data stable; cmd_ready=0; no extra rf_wrt_enable pulse; next command accepted only after the handshake.
6. Assert rst for 1 cycle while in EX of ADD r6=r1+r2 (r6 preloaded 0x00AA) -> rf_wrt_enable never pulses; r6 still 0x00AA; resp_valid=0 and cmd_ready=1 the cycle after reset.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg
// Shared constants for the register-file sequencer: command opcodes and
// FSM state encodings. Imported by regfile_sequencer and regfile_seq_alu.
package regfile_seq_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_READ  = 2'b00;
  localparam op_t OP_WRITE = 2'b01;
  localparam op_t OP_ADD   = 2'b10;
  localparam op_t OP_SUB   = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_RSP  = 3'd4;

endpackage

// File: rtl/regfile_seq_alu.sv
// regfile_seq_alu
// Combinational result/flag generator for the sequencer.
// Ports:
//   op     in  opcode (READ/WRITE/ADD/SUB)
//   a, b   in  operands (register file read data 1/2)
//   result out WORD_SIZE-bit result, wraps modulo 2^WORD_SIZE
//   flag   out carry for ADD, unsigned borrow for SUB, 0 otherwise
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [1:0]           op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] result,
  output logic                 flag
);

  logic [WORD_SIZE:0] sum;
  logic [WORD_SIZE:0] diff;

  // Zero-extended to WORD_SIZE+1 bits: the top bit of the sum is the carry,
  // and the top bit of the difference is set exactly when a < b.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = a;
    flag   = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WORD_SIZE-1:0];
        flag   = sum[WORD_SIZE];
      end
      OP_SUB: begin
        result = diff[WORD_SIZE-1:0];
        flag   = diff[WORD_SIZE];
      end
      default: begin
        result = a;
        flag   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
// Command-driven master for a register file with one-cycle registered reads.
// Accepts one READ/WRITE/ADD/SUB command at a time and returns one response.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op/dst/src1/src2/data command fields
//   resp_valid/resp_ready     response handshake
//   resp_data/resp_flag       result and carry/borrow
//   rf_rd_addr1/2, rf_rd_data1/2  register file read ports
//   rf_wrt_addr/data/enable   register file write port
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_SIZE-1:0] cmd_dst,
  input  logic [ADDR_SIZE-1:0] cmd_src1,
  input  logic [ADDR_SIZE-1:0] cmd_src2,
  input  logic [WORD_SIZE-1:0] cmd_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_SIZE-1:0] resp_data,
  output logic                 resp_flag,
  output logic [ADDR_SIZE-1:0] rf_rd_addr1,
  output logic [ADDR_SIZE-1:0] rf_rd_addr2,
  input  logic [WORD_SIZE-1:0] rf_rd_data1,
  input  logic [WORD_SIZE-1:0] rf_rd_data2,
  output logic [ADDR_SIZE-1:0] rf_wrt_addr,
  output logic [WORD_SIZE-1:0] rf_wrt_data,
  output logic                 rf_wrt_enable
);

  logic [2:0]           state_q,  state_d;
  logic [1:0]           op_q,     op_d;
  logic [ADDR_SIZE-1:0] dst_q,    dst_d;
  logic [ADDR_SIZE-1:0] src1_q,   src1_d;
  logic [ADDR_SIZE-1:0] src2_q,   src2_d;
  logic [WORD_SIZE-1:0] data_q,   data_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 flag_q,   flag_d;

  logic [WORD_SIZE-1:0] alu_result;
  logic                 alu_flag;

  regfile_seq_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .op     (op_q),
    .a      (rf_rd_data1),
    .b      (rf_rd_data2),
    .result (alu_result),
    .flag   (alu_flag)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    data_d   = data_q;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          src1_d  = cmd_src1;
          src2_d  = cmd_src2;
          data_d  = cmd_data;
          state_d = (cmd_op == OP_WRITE) ? ST_WB : ST_RD;
        end
      end
      // Register file samples src1_q/src2_q at the end of this cycle.
      ST_RD: state_d = ST_EX;
      ST_EX: begin
        result_d = alu_result;
        flag_d   = alu_flag;
        state_d  = (op_q == OP_READ) ? ST_RSP : ST_WB;
      end
      ST_WB: begin
        if (op_q == OP_WRITE) begin
          result_d = data_q;
          flag_d   = 1'b0;
        end
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      data_q   <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      data_q   <= data_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign resp_valid    = (state_q == ST_RSP);
  assign resp_data     = result_q;
  assign resp_flag     = flag_q;
  assign rf_rd_addr1   = src1_q;
  assign rf_rd_addr2   = src2_q;
  assign rf_wrt_addr   = dst_q;
  // WRITE carries its immediate; ADD/SUB write back the registered result.
  assign rf_wrt_data   = (op_q == OP_WRITE) ? data_q : result_q;
  assign rf_wrt_enable = (state_q == ST_WB);

endmodule
